alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the combinational divider and the other ALU datapath units.
- Captures quotient/result, remainder and the four CPSR condition bits behind a valid/ready handshake, with a 2-entry skid buffer so the deep combinational divide path ends at a register.
- Commits flags in order into the architectural CPSR.
- Converts divide-by-zero (invalid) results into a defined zero result plus a sticky exception flag.

Parameters:
- WIDTH, 16, datapath width of result and remainder.
- CNT_WIDTH, 8, width of the saturating invalid-operation counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  upstream result valid.
- in_ready  output  1  stage can accept (skid entry empty).
- in_result  input  WIDTH  quotient / ALU result.
- in_rem  input  WIDTH  remainder (zero for non-divide ops).
- in_negative  input  1  N flag from producer.
- in_zero  input  1  Z flag from producer.
- in_cout  input  1  C flag from producer.
- in_overflow  input  1  V flag from producer.
- in_invalid  input  1  divide-by-zero indication.
- in_set_flags  input  1  instruction updates CPSR.
- out_valid  output  1  output entry valid.
- out_ready  input  1  downstream accepts.
- out_result  output  WIDTH  registered result.
- out_rem  output  WIDTH  registered remainder.
- out_invalid  output  1  entry was divide-by-zero.
- cpsr_nzcv  output  4  architectural flags {N,Z,C,V}.
- dbz_sticky  output  1  sticky divide-by-zero exception.
- clr_exc  input  1  clears dbz_sticky and invalid_cnt.
- invalid_cnt  output  CNT_WIDTH  saturating count of retired invalid entries.

Behaviour:
- Reset and clock: clk rising edge only; rst is synchronous and active-high.
- Reset values: out_valid=0, out_result=0, out_rem=0, out_invalid=0, cpsr_nzcv=4'b0000, dbz_sticky=0, invalid_cnt=0, skid empty, in_ready=1 in the cycle after reset deasserts. All in-flight entries are dropped on reset.
- Entry fields: result, rem, nzcv, invalid, set_flags. Two slots: OUT (drives outputs) and SKID.
- Accept: in_valid & in_ready. in_ready is a registered signal equal to !skid_valid; it never depends combinationally on out_ready.
- Pop: out_valid & out_ready.
- Slot update per cycle:
  - Accept with OUT empty or popping → data loads into OUT.
  - Accept with OUT held (valid, not popping) → data loads into SKID.
  - Pop with SKID valid → SKID moves to OUT and SKID becomes empty.
  - Simultaneous pop and accept with SKID valid cannot occur, because in_ready=0 while SKID is valid.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 entry/cycle when out_ready is held high.
- Ordering: strict FIFO order.
- Invalid sanitising (applied at capture): if in_invalid=1, the stored result, rem and nzcv are forced to 0 and invalid=1 is stored.
- Commit, on pop only:
  - If set_flags=1 and invalid=0, cpsr_nzcv takes the entry's nzcv in the cycle after pop.
  - If invalid=1, cpsr_nzcv is unchanged, dbz_sticky is set and invalid_cnt increments, saturating at all-ones.
- Simultaneous clr_exc and invalid pop: the set wins. dbz_sticky=1 and invalid_cnt=1 (cleared, then incremented).
- Held output: out_* stay stable while out_valid=1 and out_ready=0.
- Flag width rule: nzcv is concatenated MSB-first as {negative, zero, cout, overflow}. No arithmetic is performed on the result data.

Decomposition:
- Shared package holds:
  - The entry field widths and an NZCV bit-index constant set: N=3, Z=2, C=1, V=0.
  - The entry struct typedef: result, rem, nzcv, invalid, set_flags.
- One natural sub-module: result_skid_buffer, a generic 2-slot valid/ready skid parameterised by payload width.
- The parent module keeps sanitising, CPSR commit, sticky flag and counter logic.

Test Plan:
- Stream, out_ready=1: 3 back-to-back entries, in_result=16'h000E/16'hFFF2/16'h0000 with matching flags and set_flags=1 → outputs appear in order 1 cycle after each accept. cpsr_nzcv becomes 4'b0000, then 4'b1000, then 4'b0100. in_ready stays 1 throughout.
- Backpressure: out_ready=0, 3 entries offered → the first two are accepted, in_ready=0 from the cycle after the second accept, and the third is held. Raising out_ready drains all three in order with no loss or duplication.
- Divide by zero: in_invalid=1, in_result=16'hBEEF, set_flags=1, cpsr previously 4'b1000 → out_result=0, out_rem=0, out_invalid=1. cpsr stays 4'b1000, dbz_sticky=1, invalid_cnt=1.
- Clear collision: clr_exc=1 in the same cycle as an invalid pop, with invalid_cnt=5 → dbz_sticky=1 and invalid_cnt=1. clr_exc alone next cycle → both 0.
- Saturation: 260 invalid pops with CNT_WIDTH=8 → invalid_cnt holds 8'hFF.
- Reset mid-operation: both slots full, rst=1 for one cycle → out_valid=0, in_ready=1 the following cycle, cpsr_nzcv=0, and no stale entry ever reaches the output.

Source files
------------

// File: rtl/alu_result_stage_pkg.sv
`default_nettype none
// ============================================================================
// alu_result_stage_pkg : entry layout and NZCV bit positions for the stage
// Revision 1.0
// ============================================================================
package alu_result_stage_pkg;

  localparam int RESULT_W = 16;
  localparam int NZCV_W   = 4;

  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  typedef struct packed {
    logic [RESULT_W-1:0] result;
    logic [RESULT_W-1:0] rem;
    logic [NZCV_W-1:0]   nzcv;
    logic                invalid;
    logic                set_flags;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

endpackage : alu_result_stage_pkg
`default_nettype wire

// File: rtl/alu_result_stage_if.sv
`default_nettype none
// ============================================================================
// alu_result_stage_if : producer/consumer/exception signals of the stage
// Revision 1.0
// ============================================================================
interface alu_result_stage_if #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_result;
  logic [WIDTH-1:0]     in_rem;
  logic                 in_negative;
  logic                 in_zero;
  logic                 in_cout;
  logic                 in_overflow;
  logic                 in_invalid;
  logic                 in_set_flags;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_result;
  logic [WIDTH-1:0]     out_rem;
  logic                 out_invalid;
  logic [3:0]           cpsr_nzcv;
  logic                 dbz_sticky;
  logic                 clr_exc;
  logic [CNT_WIDTH-1:0] invalid_cnt;

  modport master (
    output in_valid, in_result, in_rem, in_negative, in_zero, in_cout,
           in_overflow, in_invalid, in_set_flags, out_ready, clr_exc,
    input  in_ready, out_valid, out_result, out_rem, out_invalid,
           cpsr_nzcv, dbz_sticky, invalid_cnt
  );

  modport slave (
    input  in_valid, in_result, in_rem, in_negative, in_zero, in_cout,
           in_overflow, in_invalid, in_set_flags, out_ready, clr_exc,
    output in_ready, out_valid, out_result, out_rem, out_invalid,
           cpsr_nzcv, dbz_sticky, invalid_cnt
  );

endinterface : alu_result_stage_if
`default_nettype wire

// File: rtl/alu_result_stage_skid.sv
`default_nettype none
// ============================================================================
// result_skid_buffer : generic 2-slot valid/ready skid with registered ready
// Revision 1.0
// ============================================================================
module result_skid_buffer #(
  parameter int PAYLOAD_W = 8
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 in_valid,
  output logic                      in_ready,
  input  wire logic [PAYLOAD_W-1:0] in_data,
  output logic                      out_valid,
  input  wire logic                 out_ready,
  output logic [PAYLOAD_W-1:0]      out_data
);

  logic                 r_out_valid;
  logic                 r_skid_valid;
  logic                 r_in_ready;
  logic [PAYLOAD_W-1:0] r_out_data;
  logic [PAYLOAD_W-1:0] r_skid_data;

  logic w_accept, w_pop, w_promote, w_load_out, w_load_skid;
  logic w_out_valid_nxt, w_skid_valid_nxt;

  // in_ready is low whenever SKID is occupied, so promote and accept never coincide.
  always_comb begin
    w_accept         = in_valid & r_in_ready;
    w_pop            = r_out_valid & out_ready;
    w_promote        = w_pop & r_skid_valid;
    w_load_out       = w_accept & (~r_out_valid | w_pop);
    w_load_skid      = w_accept & r_out_valid & ~w_pop;
    w_out_valid_nxt  = w_promote | w_load_out | (r_out_valid & ~w_pop);
    w_skid_valid_nxt = (r_skid_valid & ~w_promote) | w_load_skid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
      r_out_data   <= '0;
      r_skid_data  <= '0;
    end else begin
      r_out_valid  <= w_out_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= ~w_skid_valid_nxt;
      if (w_promote)
        r_out_data <= r_skid_data;
      else if (w_load_out)
        r_out_data <= in_data;
      if (w_load_skid)
        r_skid_data <= in_data;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule : result_skid_buffer
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// alu_result_stage : registered ALU/divider result stage with CPSR commit
// Revision 1.0
// ============================================================================
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int WIDTH     = RESULT_W,
  parameter int CNT_WIDTH = 8
) (
  input  wire logic          clk,
  input  wire logic          rst,
  alu_result_stage_if.slave  bus
);

  entry_t w_in_entry;
  entry_t w_out_entry;
  logic   w_out_valid;
  logic   w_pop;

  logic [3:0]           r_cpsr_nzcv;
  logic                 r_dbz_sticky;
  logic [CNT_WIDTH-1:0] r_invalid_cnt;

  // Divide-by-zero entries are zeroed at capture so no garbage ever leaves the stage.
  always_comb begin
    w_in_entry                   = '0;
    w_in_entry.invalid           = bus.in_invalid;
    w_in_entry.set_flags         = bus.in_set_flags;
    if (!bus.in_invalid) begin
      w_in_entry.result          = bus.in_result;
      w_in_entry.rem             = bus.in_rem;
      w_in_entry.nzcv[NZCV_N]    = bus.in_negative;
      w_in_entry.nzcv[NZCV_Z]    = bus.in_zero;
      w_in_entry.nzcv[NZCV_C]    = bus.in_cout;
      w_in_entry.nzcv[NZCV_V]    = bus.in_overflow;
    end
  end

  result_skid_buffer #(
    .PAYLOAD_W (ENTRY_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (w_in_entry),
    .out_valid (w_out_valid),
    .out_ready (bus.out_ready),
    .out_data  (w_out_entry)
  );

  assign w_pop = w_out_valid & bus.out_ready;

  // An invalid retire overrides a same-cycle clear: count restarts at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cpsr_nzcv   <= 4'b0000;
      r_dbz_sticky  <= 1'b0;
      r_invalid_cnt <= '0;
    end else begin
      if (w_pop && w_out_entry.set_flags && !w_out_entry.invalid)
        r_cpsr_nzcv <= w_out_entry.nzcv;
      if (w_pop && w_out_entry.invalid) begin
        r_dbz_sticky <= 1'b1;
        if (bus.clr_exc)
          r_invalid_cnt <= CNT_WIDTH'(1);
        else if (r_invalid_cnt != {CNT_WIDTH{1'b1}})
          r_invalid_cnt <= r_invalid_cnt + 1'b1;
      end else if (bus.clr_exc) begin
        r_dbz_sticky  <= 1'b0;
        r_invalid_cnt <= '0;
      end
    end
  end

  assign bus.out_valid   = w_out_valid;
  assign bus.out_result  = w_out_entry.result;
  assign bus.out_rem     = w_out_entry.rem;
  assign bus.out_invalid = w_out_entry.invalid;
  assign bus.cpsr_nzcv   = r_cpsr_nzcv;
  assign bus.dbz_sticky  = r_dbz_sticky;
  assign bus.invalid_cnt = r_invalid_cnt;

endmodule : alu_result_stage
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
// tb_alu_result_stage : directed self-checking bench for alu_result_stage
// Revision 1.0
// ============================================================================
module tb_alu_result_stage;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_result_stage_if #(.WIDTH(16), .CNT_WIDTH(8)) bus ();

  alu_result_stage #(.WIDTH(16), .CNT_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] res, input logic [15:0] rem,
                       input logic [3:0] nzcv, input logic inv, input logic sf);
    bus.in_valid     = v;
    bus.in_result    = res;
    bus.in_rem       = rem;
    bus.in_negative  = nzcv[3];
    bus.in_zero      = nzcv[2];
    bus.in_cout      = nzcv[1];
    bus.in_overflow  = nzcv[0];
    bus.in_invalid   = inv;
    bus.in_set_flags = sf;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    bus.clr_exc   = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_result !== 16'h0 ||
        bus.out_rem !== 16'h0 || bus.out_invalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b ready=%b result=%h rem=%h inv=%b, required 0 1 0000 0000 0",
               bus.out_valid, bus.in_ready, bus.out_result, bus.out_rem, bus.out_invalid);
    end
    checks++;
    if (bus.cpsr_nzcv !== 4'b0000 || bus.dbz_sticky !== 1'b0 || bus.invalid_cnt !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: cpsr=%b sticky=%b cnt=%h, required 0000 0 00",
               bus.cpsr_nzcv, bus.dbz_sticky, bus.invalid_cnt);
    end
  endtask

  task automatic test_stream();
    logic [15:0] res [3]  = '{16'h000E, 16'hFFF2, 16'h0000};
    logic [3:0]  nz  [3]  = '{4'b0000, 4'b1000, 4'b0100};
    logic [3:0]  cp  [4]  = '{4'b0000, 4'b0000, 4'b1000, 4'b0100};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, res[i], 16'h0, nz[i], 1'b0, 1'b1);
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== res[i] || bus.in_ready !== 1'b1 ||
          bus.cpsr_nzcv !== cp[i]) begin
        errors++;
        $display("FAIL stream_%0d: valid=%b result=%h ready=%b cpsr=%b, required 1 %h 1 %b",
                 i, bus.out_valid, bus.out_result, bus.in_ready, bus.cpsr_nzcv, res[i], cp[i]);
      end
    end
    drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0);
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.cpsr_nzcv !== cp[3]) begin
      errors++;
      $display("FAIL stream_drain: valid=%b cpsr=%b, required 0 %b",
               bus.out_valid, bus.cpsr_nzcv, cp[3]);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h1111, 16'h0001, 4'b1111, 1'b0, 1'b0);
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h1111 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_first: valid=%b result=%h ready=%b, required 1 1111 1",
               bus.out_valid, bus.out_result, bus.in_ready);
    end
    drive(1'b1, 16'h2222, 16'h0002, 4'b1111, 1'b0, 1'b0);
    step();
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_result !== 16'h1111 || bus.out_rem !== 16'h0001) begin
      errors++;
      $display("FAIL bp_skid_full: ready=%b result=%h rem=%h, required 0 1111 0001",
               bus.in_ready, bus.out_result, bus.out_rem);
    end
    drive(1'b1, 16'h3333, 16'h0003, 4'b1111, 1'b0, 1'b0);
    step();
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_result !== 16'h1111 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_held: ready=%b result=%h valid=%b, required 0 1111 1",
               bus.in_ready, bus.out_result, bus.out_valid);
    end
    bus.out_ready = 1'b1;
    step();
    checks++;
    if (bus.out_result !== 16'h2222 || bus.out_rem !== 16'h0002 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain_2: result=%h rem=%h ready=%b, required 2222 0002 1",
               bus.out_result, bus.out_rem, bus.in_ready);
    end
    step();
    drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0);
    checks++;
    if (bus.out_result !== 16'h3333 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain_3: result=%h valid=%b, required 3333 1",
               bus.out_result, bus.out_valid);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.cpsr_nzcv !== 4'b0100) begin
      errors++;
      $display("FAIL bp_empty: valid=%b cpsr=%b, required 0 0100", bus.out_valid, bus.cpsr_nzcv);
    end
  endtask

  task automatic test_dbz();
    bus.out_ready = 1'b1;
    drive(1'b1, 16'hFFF2, 16'h0, 4'b1000, 1'b0, 1'b1);
    step();
    drive(1'b1, 16'hBEEF, 16'h1234, 4'b1111, 1'b1, 1'b1);
    step();
    drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h0 || bus.out_rem !== 16'h0 ||
        bus.out_invalid !== 1'b1 || bus.cpsr_nzcv !== 4'b1000) begin
      errors++;
      $display("FAIL dbz_output: valid=%b result=%h rem=%h inv=%b cpsr=%b, required 1 0000 0000 1 1000",
               bus.out_valid, bus.out_result, bus.out_rem, bus.out_invalid, bus.cpsr_nzcv);
    end
    step();
    checks++;
    if (bus.cpsr_nzcv !== 4'b1000 || bus.dbz_sticky !== 1'b1 || bus.invalid_cnt !== 8'd1) begin
      errors++;
      $display("FAIL dbz_commit: cpsr=%b sticky=%b cnt=%0d, required 1000 1 1",
               bus.cpsr_nzcv, bus.dbz_sticky, bus.invalid_cnt);
    end
  endtask

  task automatic test_clear_collision();
    bus.out_ready = 1'b1;
    drive(1'b1, 16'hDEAD, 16'h0, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step();
    drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0);
    step();
    checks++;
    if (bus.invalid_cnt !== 8'd5) begin
      errors++;
      $display("FAIL clr_precount: cnt=%0d, required 5", bus.invalid_cnt);
    end
    drive(1'b1, 16'hDEAD, 16'h0, 4'h0, 1'b1, 1'b0);
    step();
    drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0);
    bus.clr_exc = 1'b1;
    step();
    bus.clr_exc = 1'b0;
    checks++;
    if (bus.dbz_sticky !== 1'b1 || bus.invalid_cnt !== 8'd1) begin
      errors++;
      $display("FAIL clr_collision: sticky=%b cnt=%0d, required 1 1", bus.dbz_sticky, bus.invalid_cnt);
    end
    bus.clr_exc = 1'b1;
    step();
    bus.clr_exc = 1'b0;
    checks++;
    if (bus.dbz_sticky !== 1'b0 || bus.invalid_cnt !== 8'd0) begin
      errors++;
      $display("FAIL clr_alone: sticky=%b cnt=%0d, required 0 0", bus.dbz_sticky, bus.invalid_cnt);
    end
  endtask

  task automatic test_saturation();
    bus.out_ready = 1'b1;
    drive(1'b1, 16'h5555, 16'h0, 4'b0110, 1'b1, 1'b1);
    for (int i = 0; i < 260; i++) step();
    drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0);
    step();
    step();
    checks++;
    if (bus.invalid_cnt !== 8'hFF || bus.dbz_sticky !== 1'b1 || bus.cpsr_nzcv !== 4'b1000) begin
      errors++;
      $display("FAIL saturation: cnt=%h sticky=%b cpsr=%b, required ff 1 1000",
               bus.invalid_cnt, bus.dbz_sticky, bus.cpsr_nzcv);
    end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    drive(1'b1, 16'hAAAA, 16'h0, 4'b1111, 1'b0, 1'b1);
    step();
    drive(1'b1, 16'hBBBB, 16'h0, 4'b1111, 1'b0, 1'b1);
    step();
    drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_full: ready=%b valid=%b, required 0 1", bus.in_ready, bus.out_valid);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.cpsr_nzcv !== 4'b0000 ||
        bus.invalid_cnt !== 8'h00 || bus.dbz_sticky !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after: valid=%b ready=%b cpsr=%b cnt=%h sticky=%b, required 0 1 0000 00 0",
               bus.out_valid, bus.in_ready, bus.cpsr_nzcv, bus.invalid_cnt, bus.dbz_sticky);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.cpsr_nzcv !== 4'b0000) begin
        errors++;
        $display("FAIL rstmid_stale_%0d: valid=%b cpsr=%b, required 0 0000",
                 i, bus.out_valid, bus.cpsr_nzcv);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_dbz();
    test_clear_collision();
    test_saturation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_alu_result_stage
`default_nettype wire
